comparator_sweep_checker: RTL and testbench

- Hardware stimulus/checker that drives the other end of the magnitude-comparator interface.
- Generates every (A, B) operand pair in order: A is the outer loop, B the inner loop, both ascending.
- For each pair it samples the external comparator's Eq/Gt/Sm outputs after a settle interval and checks them against expected values.
- Reports error count, first failing pair, and pass/fail. Used as a built-in self-test wrapper around any comparator_* implementation.

---
 rtl/comparator_sweep_checker_if.sv | 13 +
 rtl/comparator_sweep_checker.sv | 129 ++++++++++++
 tb/tb_comparator_sweep_checker.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/comparator_sweep_checker_if.sv
// Operand/result bus between the sweep checker (master) and the comparator under test (slave).
interface comparator_sweep_checker_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             eq_in;
  logic             gt_in;
  logic             sm_in;

  modport master (output a_out, b_out, input eq_in, gt_in, sm_in);
  modport slave  (input a_out, b_out, output eq_in, gt_in, sm_in);
endinterface

// File: rtl/comparator_sweep_checker.sv
// Exhaustive (A,B) sweep self-test for a magnitude comparator: drives operands, checks Eq/Gt/Sm.
// Optional macro STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module comparator_sweep_checker #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  comparator_sweep_checker_if.master    cmp,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [2*WIDTH:0]              err_count,
  output logic                          fail_valid,
  output logic [WIDTH-1:0]              fail_a,
  output logic [WIDTH-1:0]              fail_b
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [3:0]       SETTLE_LD   = 4'(SETTLE_CYCLES);
  localparam logic [WIDTH-1:0] ALL_ONES    = '1;
  localparam bit               ZERO_SETTLE = (SETTLE_CYCLES == 0);
`ifdef STOP_ON_FAIL_EN
  localparam bit               STOP_ON_FAIL = 1'b1;
`else
  localparam bit               STOP_ON_FAIL = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2*WIDTH:0] err_q, err_d;
  logic             fv_q, fv_d;
  logic [WIDTH-1:0] fa_q, fa_d, fb_q, fb_d;
  logic             mismatch, last_pair;

  // Any differing bit fails the vector, so non-one-hot responses always fail.
  function automatic logic vec_mismatch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                        input logic eq, input logic gt, input logic sm);
    return {eq, gt, sm} != {a == b, a > b, a < b};
  endfunction

  assign mismatch  = vec_mismatch(a_q, b_q, cmp.eq_in, cmp.gt_in, cmp.sm_in);
  assign last_pair = (a_q == ALL_ONES) && (b_q == ALL_ONES);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = '0;
          b_d     = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          fa_d    = '0;
          fb_d    = '0;
          cnt_d   = SETTLE_LD;
          state_d = ZERO_SETTLE ? CHECK : SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd1) state_d = CHECK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      CHECK: begin
        if (mismatch) begin
          err_d = err_q + (2*WIDTH+1)'(1);
          if (!fv_q) begin
            fv_d = 1'b1;
            fa_d = a_q;
            fb_d = b_q;
          end
        end
        // Terminating vectors leave the operands on the last pair checked.
        if (last_pair || (STOP_ON_FAIL && mismatch)) begin
          state_d = DONE;
        end else begin
          b_d = b_q + WIDTH'(1);
          if (b_q == ALL_ONES) a_d = a_q + WIDTH'(1);
          cnt_d   = SETTLE_LD;
          state_d = ZERO_SETTLE ? CHECK : SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fa_q    <= '0;
      fb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
    end
  end

  assign cmp.a_out  = a_q;
  assign cmp.b_out  = b_q;
  assign busy       = (state_q == SETTLE) || (state_q == CHECK);
  assign done       = (state_q == DONE);
  assign pass       = done && (err_q == '0);
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign fail_a     = fa_q;
  assign fail_b     = fb_q;

endmodule

// File: tb/tb_comparator_sweep_checker.sv
// Bench for comparator_sweep_checker: two instances (settle 1 and settle 0) sharing a faultable comparator model.
module tb_comparator_sweep_checker;

`ifdef STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic start1, start0;
  logic sel;
  int   npass = 0;
  int   ntot  = 0;

  // Per-vector XOR fault applied to the ideal comparator: bit2=eq, bit1=gt, bit0=sm.
  logic [2:0] flip [256];

  logic       busy1, done1, pass1, fv1, busy0, done0, pass0, fv0;
  logic [8:0] err1, err0;
  logic [3:0] fa1, fb1, fa0, fb0;

  comparator_sweep_checker_if #(.WIDTH(4)) if1 ();
  comparator_sweep_checker_if #(.WIDTH(4)) if0 ();

  always #5 clk = ~clk;

  assign if1.eq_in = (if1.a_out == if1.b_out) ^ flip[{if1.a_out, if1.b_out}][2];
  assign if1.gt_in = (if1.a_out >  if1.b_out) ^ flip[{if1.a_out, if1.b_out}][1];
  assign if1.sm_in = (if1.a_out <  if1.b_out) ^ flip[{if1.a_out, if1.b_out}][0];
  assign if0.eq_in = (if0.a_out == if0.b_out) ^ flip[{if0.a_out, if0.b_out}][2];
  assign if0.gt_in = (if0.a_out >  if0.b_out) ^ flip[{if0.a_out, if0.b_out}][1];
  assign if0.sm_in = (if0.a_out <  if0.b_out) ^ flip[{if0.a_out, if0.b_out}][0];

  comparator_sweep_checker #(.WIDTH(4), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cmp(if1.master),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1));

  comparator_sweep_checker #(.WIDTH(4), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .cmp(if0.master),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_valid(fv0), .fail_a(fa0), .fail_b(fb0));

  logic       busy_s, done_s, pass_s, fv_s;
  logic [8:0] err_s;
  logic [3:0] a_s, b_s, fa_s, fb_s;
  assign busy_s = sel ? busy0 : busy1;
  assign done_s = sel ? done0 : done1;
  assign pass_s = sel ? pass0 : pass1;
  assign fv_s   = sel ? fv0   : fv1;
  assign err_s  = sel ? err0  : err1;
  assign a_s    = sel ? if0.a_out : if1.a_out;
  assign b_s    = sel ? if0.b_out : if1.b_out;
  assign fa_s   = sel ? fa0 : fa1;
  assign fb_s   = sel ? fb0 : fb1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic fill_table(input int kind);
    for (int i = 0; i < 256; i++) begin
      case (kind)
        1:       flip[i] = {1'b0, (i / 16) > (i % 16), 1'b0};
        2:       flip[i] = 3'b100;
        3:       flip[i] = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        default: flip[i] = 3'b000;
      endcase
    end
  endtask

  // extra: 1 = re-pulse start mid-sweep and probe operands, 2 = probe first-error edge (settle 0)
  task automatic run_sweep(input bit s0, input int extra, input string tag);
    int first, cnt, done_at, s, idle;
    logic [3:0] exp_a, exp_b, exp_fa, exp_fb;
    sel   = s0;
    s     = s0 ? 0 : 1;
    first = -1;
    cnt   = 0;
    for (int i = 0; i < 256; i++) begin
      if (flip[i] != 3'b000) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    exp_fa = (first >= 0) ? 4'(first / 16) : 4'h0;
    exp_fb = (first >= 0) ? 4'(first % 16) : 4'h0;
    if (STOP && first >= 0) begin
      done_at = (first + 1) * (s + 1);
      cnt     = 1;
      exp_a   = exp_fa;
      exp_b   = exp_fb;
    end else begin
      done_at = 256 * (s + 1);
      exp_a   = 4'hF;
      exp_b   = 4'hF;
    end
    idle = $urandom_range(0, 3);
    repeat (idle) begin @(posedge clk); #1; end
    if (s0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    chk({tag, "_busy_e0"}, 32'(busy_s), 32'd1);
    for (int e = 1; e <= done_at; e++) begin
      @(posedge clk); #1;
      if (extra == 1 && e == 49) start1 = 1'b1;
      if (extra == 1 && e == 50) start1 = 1'b0;
      if (extra == 1 && e == 100) begin
        chk({tag, "_a_at100"}, 32'(a_s), 32'd3);
        chk({tag, "_b_at100"}, 32'(b_s), 32'd2);
      end
      if (extra == 2 && e == 16) chk({tag, "_err_at16"}, 32'(err_s), 32'd0);
      if (extra == 2 && e == 17) chk({tag, "_err_at17"}, 32'(err_s), 32'd1);
      if (e == done_at - 1) chk({tag, "_done_early"}, 32'(done_s), 32'd0);
    end
    chk({tag, "_done"},  32'(done_s), 32'd1);
    chk({tag, "_busy"},  32'(busy_s), 32'd0);
    chk({tag, "_err"},   32'(err_s),  32'(cnt));
    chk({tag, "_pass"},  32'(pass_s), 32'(cnt == 0));
    chk({tag, "_fv"},    32'(fv_s),   32'(first >= 0));
    chk({tag, "_fa"},    32'(fa_s),   32'(exp_fa));
    chk({tag, "_fb"},    32'(fb_s),   32'(exp_fb));
    chk({tag, "_a_end"}, 32'(a_s),    32'(exp_a));
    chk({tag, "_b_end"}, 32'(b_s),    32'(exp_b));
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_a"},    32'(a_s),    32'd0);
    chk({tag, "_b"},    32'(b_s),    32'd0);
    chk({tag, "_err"},  32'(err_s),  32'd0);
    chk({tag, "_fv"},   32'(fv_s),   32'd0);
    chk({tag, "_fa"},   32'(fa_s),   32'd0);
    chk({tag, "_fb"},   32'(fb_s),   32'd0);
    chk({tag, "_busy"}, 32'(busy_s), 32'd0);
    chk({tag, "_done"}, 32'(done_s), 32'd0);
    chk({tag, "_pass"}, 32'(pass_s), 32'd0);
  endtask

  initial begin
    rst_n  = 1'b1;
    start1 = 1'b0;
    start0 = 1'b0;
    sel    = 1'b0;
    fill_table(0);
    #2 rst_n = 1'b0;
    #1 chk_cleared("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_sweep(1'b0, 1, "good_s1");
    fill_table(1);
    run_sweep(1'b0, 0, "gtstuck_s1");
    fill_table(2);
    run_sweep(1'b0, 0, "eqinv_s1");
    fill_table(0);
    run_sweep(1'b1, 0, "good_s0");
    fill_table(1);
    run_sweep(1'b1, 2, "gtstuck_s0");

    // Reset in the middle of a failing sweep, then a clean sweep from scratch
    sel    = 1'b0;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (99) @(posedge clk);
    #1 chk("midrst_fv_before", 32'(fv_s), 32'd1);
    rst_n = 1'b0;
    #1 chk_cleared("midrst");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    fill_table(0);
    run_sweep(1'b0, 0, "after_rst");

    fill_table(3);
    run_sweep(1'b0, 0, "rand_s1");
    fill_table(3);
    run_sweep(1'b1, 0, "rand_s0");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
